// File: rtl/unified_mem_arbiter_if.sv
// Memory-side bus of the unified arbiter.
//   master : arbiter side  (drives mem_req/mem_we/mem_addr/mem_wdata)
//   slave  : memory side   (drives mem_rdata/mem_ready)
// mem_rdata is valid only in the cycle mem_ready is high.
interface unified_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) ();
  logic                  mem_req;
  logic [SEL_WIDTH-1:0]  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between the core's fetch (ROM) port and
// data (RAM) port. Each core step: SAMPLE latches the core request, DATA
// runs the load/store (only if ram_en), FETCH reads the instruction, and
// RELEASE drops core_stall for one cycle with both results on the read buses.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rom_addr        core fetch address         -> rom_read_data (registered)
//   ram_en/_write_en/_addr/_write_data  core data request -> ram_read_data
//   core_stall      drives the core stall input
//   mem             memory bus (master modport)
//   bus_error       one-cycle pulse when an access times out
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [DATA_WIDTH-1:0] rom_read_data,
  input  logic                  ram_en,
  input  logic [SEL_WIDTH-1:0]  ram_write_en,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_write_data,
  output logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  core_stall,
  unified_mem_arbiter_if.master mem,
  output logic                  bus_error
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {SAMPLE, DATA, FETCH, RELEASE} state_t;

  typedef struct packed {
    logic [SEL_WIDTH-1:0]  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] rom_addr;
  } req_t;

  state_t        state, state_nxt;
  req_t          req_q;
  logic [TW-1:0] tmo_cnt;
  logic          in_access;
  logic          tmo_hit;
  logic          acc_done;

  // ready is only meaningful while an access is actually on the bus
  assign in_access = (state == DATA) || (state == FETCH);
  assign tmo_hit   = in_access && !mem.mem_ready && (tmo_cnt == TW'(TIMEOUT - 1));
  assign acc_done  = in_access && (mem.mem_ready || tmo_hit);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= SAMPLE;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      SAMPLE:  state_nxt = ram_en ? DATA : FETCH;
      DATA:    if (acc_done) state_nxt = FETCH;
      FETCH:   if (acc_done) state_nxt = RELEASE;
      RELEASE: state_nxt = SAMPLE;
      default: state_nxt = SAMPLE;
    endcase
  end

  // outputs; gated by rst so reset values hold for the whole reset cycle,
  // including the one before the first reset edge
  always_comb begin
    core_stall    = 1'b1;
    mem.mem_req   = 1'b0;
    mem.mem_we    = '0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (!rst) begin
      case (state)
        DATA: begin
          mem.mem_req   = 1'b1;
          mem.mem_we    = req_q.we;
          mem.mem_addr  = req_q.addr;
          mem.mem_wdata = req_q.wdata;
        end
        FETCH: begin
          mem.mem_req  = 1'b1;
          mem.mem_addr = req_q.rom_addr;
        end
        RELEASE: core_stall = 1'b0;
        default: ;
      endcase
    end
  end

  // request latch, timeout counter, result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q         <= '0;
      tmo_cnt       <= '0;
      rom_read_data <= '0;
      ram_read_data <= '0;
      bus_error     <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      case (state)
        SAMPLE: begin
          req_q.we       <= ram_write_en;
          req_q.addr     <= ram_addr;
          req_q.wdata    <= ram_write_data;
          req_q.rom_addr <= rom_addr;
          tmo_cnt        <= '0;
        end
        DATA, FETCH: begin
          if (acc_done) begin
            tmo_cnt   <= '0;
            bus_error <= tmo_hit;
            // a timed-out access reads back as zero
            if (state == FETCH)
              rom_read_data <= tmo_hit ? '0 : mem.mem_rdata;
            else if (req_q.we == '0)
              ram_read_data <= tmo_hit ? '0 : mem.mem_rdata;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: tmo_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rom_addr = '0;
  logic [31:0] rom_read_data;
  logic        ram_en = 1'b0;
  logic [3:0]  ram_write_en = '0;
  logic [31:0] ram_addr = '0;
  logic [31:0] ram_write_data = '0;
  logic [31:0] ram_read_data;
  logic        core_stall;
  logic        bus_error;

  unified_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4)) mif ();

  unified_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .TIMEOUT(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr      (rom_addr),
    .rom_read_data (rom_read_data),
    .ram_en        (ram_en),
    .ram_write_en  (ram_write_en),
    .ram_addr      (ram_addr),
    .ram_write_data(ram_write_data),
    .ram_read_data (ram_read_data),
    .core_stall    (core_stall),
    .mem           (mif.master),
    .bus_error     (bus_error)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // expected memory accesses, in order
  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;
  acc_t sb_q[$];
  acc_t cur;

  // memory model
  logic [31:0] mem_model [int];
  int          wait_cfg    = 0;
  bit          hold_ready  = 0;
  bit          ready_force = 1;
  int          wcnt        = 0;

  initial begin
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(int'(a)) ? mem_model[int'(a)] : 32'h0;
  endfunction

  // responder: acts 2 time units after each posedge, away from both edges
  always @(posedge clk) begin
    #2;
    if (ready_force) begin
      mif.mem_ready = 1'b1;
      wcnt = 0;
    end else if (!mif.mem_req) begin
      mif.mem_ready = 1'b0;
      wcnt = 0;
    end else begin
      if (wcnt == 0) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_access", {32'h0, mif.mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          cur = sb_q.pop_front();
          chk("acc_addr", mif.mem_addr, cur.addr);
          chk("acc_we", mif.mem_we, cur.we);
          if (cur.we != 4'b0) chk("acc_wdata", mif.mem_wdata, cur.wdata);
        end
      end else begin
        chk("hold_addr", mif.mem_addr, cur.addr);
        chk("hold_we", mif.mem_we, cur.we);
        if (cur.we != 4'b0) chk("hold_wdata", mif.mem_wdata, cur.wdata);
      end
      if (!hold_ready && wcnt == wait_cfg) begin
        mif.mem_ready = 1'b1;
        mif.mem_rdata = mem_rd(mif.mem_addr);
        if (mif.mem_we != 4'b0) begin
          logic [31:0] w;
          w = mem_rd(mif.mem_addr);
          for (int b = 0; b < 4; b++)
            if (mif.mem_we[b]) w[8*b +: 8] = mif.mem_wdata[8*b +: 8];
          mem_model[int'(mif.mem_addr)] = w;
        end
        wcnt = 0;
      end else begin
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 32'hBAD0_BAD0;
        wcnt++;
      end
    end
  end

  int be_cnt = 0;
  always @(negedge clk) if (bus_error === 1'b1) be_cnt++;

  // Run one core step; called at the negedge of a SAMPLE cycle, returns at
  // the negedge of RELEASE (or when the cycle budget runs out).
  task automatic step(input string tag, input logic en, input logic [3:0] we,
                      input logic [31:0] ra, input logic [31:0] wd,
                      input logic [31:0] fa, input int exp_n);
    int n;
    chk({tag, "_stall_in_sample"}, core_stall, 1);
    ram_en = en; ram_write_en = we; ram_addr = ra; ram_write_data = wd; rom_addr = fa;
    if (en) sb_q.push_back(acc_t'{we, ra, wd});
    sb_q.push_back(acc_t'{4'b0, fa, 32'h0});
    n = 1;
    do begin
      @(negedge clk);
      n++;
      // core-side changes mid-access must not reach the bus
      ram_en = 1'($urandom); ram_write_en = 4'($urandom);
      ram_addr = $urandom; ram_write_data = $urandom; rom_addr = $urandom;
    end while (core_stall && n < 64);
    chk({tag, "_cycles"}, n, exp_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_model[32'h100]  = 32'h2401_0005;
    mem_model[32'h104]  = 32'h8C22_0000;
    mem_model[32'h108]  = 32'h0000_0013;
    mem_model[32'h10C]  = 32'h1234_5678;
    mem_model[32'h2000] = 32'hDEAD_BEEF;
    mem_model[32'h3000] = 32'h1122_3344;

    // reset held 3 cycles with mem_ready forced high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_stall", core_stall, 1);
      chk("rst_req", mif.mem_req, 0);
      chk("rst_rom", rom_read_data, 0);
      chk("rst_ram", ram_read_data, 0);
      chk("rst_berr", bus_error, 0);
    end
    rst = 1'b0;
    ready_force = 0;

    // fetch only, zero wait, two back-to-back steps
    wait_cfg = 0;
    step("fetch1", 1'b0, 4'b0, 32'h0, 32'h0, 32'h100, 3);
    chk("fetch1_rom", rom_read_data, 32'h2401_0005);
    @(negedge clk);
    step("fetch2", 1'b0, 4'b0, 32'h0, 32'h0, 32'h104, 3);
    chk("fetch2_rom", rom_read_data, 32'h8C22_0000);
    chk("fetch2_ram", ram_read_data, 32'h0);

    // load then fetch, 2 wait cycles each
    wait_cfg = 2;
    @(negedge clk);
    step("load", 1'b1, 4'b0, 32'h2000, 32'h5555_AAAA, 32'h104, 8);
    chk("load_ram", ram_read_data, 32'hDEAD_BEEF);
    chk("load_rom", rom_read_data, 32'h8C22_0000);

    // store: read bus unchanged
    @(negedge clk);
    step("store", 1'b1, 4'b0011, 32'h3000, 32'h0000_ABCD, 32'h108, 8);
    chk("store_ram_kept", ram_read_data, 32'hDEAD_BEEF);
    chk("store_rom", rom_read_data, 32'h0000_0013);

    // zero-wait load of the stored word
    wait_cfg = 0;
    @(negedge clk);
    step("reload", 1'b1, 4'b0, 32'h3000, 32'h0, 32'h100, 4);
    chk("reload_ram", ram_read_data, 32'h1122_ABCD);
    chk("reload_rom", rom_read_data, 32'h2401_0005);

    // fetch timeout: TIMEOUT=4 FETCH cycles, then RELEASE with bus_error
    hold_ready = 1;
    @(negedge clk);
    chk("tmo_berr_before", be_cnt, 0);
    step("tmo", 1'b0, 4'b0, 32'h0, 32'h0, 32'h10C, 6);
    chk("tmo_berr", bus_error, 1);
    chk("tmo_rom", rom_read_data, 32'h0);
    chk("tmo_ram_kept", ram_read_data, 32'h1122_ABCD);
    hold_ready = 0;
    @(negedge clk);
    chk("tmo_berr_drop", bus_error, 0);
    chk("tmo_berr_pulses", be_cnt, 1);

    // reset on the 2nd wait cycle of a load
    wait_cfg = 5;
    ram_en = 1'b1; ram_write_en = 4'b0; ram_addr = 32'h2000; rom_addr = 32'h104;
    sb_q.push_back(acc_t'{4'b0, 32'h2000, 32'h0});
    @(negedge clk);
    chk("mid_req", mif.mem_req, 1);
    @(negedge clk);
    chk("mid_req2", mif.mem_req, 1);
    rst = 1'b1;
    ready_force = 1;
    @(negedge clk);
    sb_q.delete();
    chk("mid_rst_stall", core_stall, 1);
    chk("mid_rst_req", mif.mem_req, 0);
    chk("mid_rst_ram", ram_read_data, 0);
    chk("mid_rst_rom", rom_read_data, 0);
    @(negedge clk);
    chk("mid_rst_ready_high", mif.mem_ready, 1);
    chk("mid_rst_ram2", ram_read_data, 0);
    rst = 1'b0;
    ready_force = 0;
    wait_cfg = 0;
    step("restart", 1'b0, 4'b0, 32'h0, 32'h0, 32'h100, 3);
    chk("restart_rom", rom_read_data, 32'h2401_0005);
    chk("restart_ram", ram_read_data, 32'h0);
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
